ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Shares one AHB-Lite slave bus among NUM_MASTERS testbench/RTL masters.
- Grants the bus round-robin, parks it on a default master when idle, and keeps grant through fixed-length bursts and locked sequences.
- Drives hmaster/hmastlock so the master-side address/data mux and slave interfaces see the current owner.
- Sits between the master request lines and the shared address/control mux in front of the slave interface.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..16).
- DEFAULT_MASTER, 0, bus parking owner when nobody requests.
- MW, $clog2(NUM_MASTERS), width of hmaster.

Ports:
- clk  input  1  bus clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- hbusreq  input  NUM_MASTERS  per-master bus request.
- hlock  input  NUM_MASTERS  per-master locked-access request.
- htrans  input  2  transfer type from the current address-phase owner (muxed).
- hburst  input  3  burst type from the current owner.
- hready  input  1  bus ready; a cycle with hready=1 accepts the address phase.
- hgrant  output  NUM_MASTERS  one-hot grant, registered.
- hmaster  output  MW  index of the address-phase owner, registered.
- hmastlock  output  1  current address phase is locked, registered.

Behaviour:
- Reset values:
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = DEFAULT_MASTER; hmastlock = 0.
  - rr_ptr = DEFAULT_MASTER; beat_cnt = 0; state = ST_OPEN.
- Reset mid-burst or mid-lock aborts immediately to these values.
- Accepted beat: hready=1 and htrans ∈ {NONSEQ, SEQ}. IDLE and BUSY never count as beats.
- Burst length from hburst: SINGLE=1; INCR=undefined; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
- beat_cnt is 5 bits and counts remaining beats. Load len-1 on an accepted NONSEQ of a fixed burst; decrement on each accepted SEQ.

State machine:
- ST_OPEN
  - Accepted NONSEQ with fixed burst of len>1 and hlock[hmaster]=0 -> ST_BURST.
  - hlock[hmaster]=1 on an accepted cycle -> ST_LOCK.
- ST_BURST
  - Accepted SEQ with beat_cnt==1 (last beat) -> ST_OPEN.
  - NONSEQ or IDLE mid-burst (early termination) -> ST_OPEN, beat_cnt=0.
- ST_LOCK
  - hlock[hmaster]=0 on an hready=1 cycle -> ST_LOCK_TAIL.
- ST_LOCK_TAIL
  - One hready=1 cycle with grant held (mandatory IDLE after locked sequence) -> ST_OPEN.

Arbitration:
- New grant is computed combinationally and loaded into hgrant only on an edge with hready=1, and only when one of these holds:
  - state==ST_OPEN and no fixed burst starts this cycle;
  - ST_BURST last-beat accept;
  - ST_LOCK_TAIL exit.
- Selection: first requesting master searching from (rr_ptr+1) mod NUM_MASTERS upward, with wrap-around.
  - If no hbusreq is set, select DEFAULT_MASTER.
  - If the current owner is the only requester, it keeps the grant.
- rr_ptr <= newly granted index only when grant changes to a requesting master. Parking does not move rr_ptr.
- hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)] on every edge with hready=1. Net effect: hmaster lags hgrant by one accepted cycle (address-phase handover).
- hready=0: hgrant, hmaster, hmastlock, beat_cnt and state all hold.
- INCR (undefined length): re-arbitration is allowed after any accepted beat. The owner loses the bus if another master requests.
- Invariant: hgrant is always exactly one-hot, never zero.

Decomposition:
- Package ahb_arb_pkg:
  - htrans encodings IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hburst encodings 0..7.
  - State enum arb_state_t.
  - Function burst_beats(hburst) returning 0 for INCR.
- Sub-module ahb_rr_picker: combinational round-robin find-first.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any_req.
  - Instantiated once.

Test Plan:
- Reset with hbusreq=0 -> hgrant=4'b0001, hmaster=0, hmastlock=0; hold 5 cycles, unchanged.
- hbusreq=4'b0110, continuous hready=1, SINGLE NONSEQ each cycle -> grant rotates 1,2,1,2; hmaster follows one cycle later.
- Master 2 granted, INCR8 started, master 3 requests from beat 2 -> hgrant stays 4'b0100 for 8 accepted beats, then 4'b1000 on the 8th-beat edge.
- INCR4 with hready=0 for 3 cycles at beat 2 -> beat_cnt and grant frozen; handover after 4th accepted beat only.
- Master 1 hlock=1 for 3 transfers while master 0 requests -> hmastlock=1 over those address phases; grant held plus one tail cycle, then master 0.
- rst asserted at beat 3 of INCR16 -> next cycle hgrant=one-hot(0), state ST_OPEN, beat_cnt=0.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared encodings, FSM state type and burst-length helper for the AHB bus arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;
    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;
    localparam logic [2:0] BU_WRAP16 = 3'd6;
    localparam logic [2:0] BU_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_BURST,
        ST_LOCK,
        ST_LOCK_TAIL
    } arb_state_t;

    // Undefined-length INCR reports 0 so it never pins the grant.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            BU_SINGLE:          return 5'd1;
            BU_INCR:            return 5'd0;
            BU_WRAP4, BU_INCR4: return 5'd4;
            BU_WRAP8, BU_INCR8: return 5'd8;
            default:            return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin find-first: first requester after ptr, wrapping,
// falling back to the parking master when nobody requests.
module ahb_rr_picker #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [MW-1:0]          idx,
    output logic                   any_req
);

    always_comb begin
        logic          found;
        logic [MW-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        idx     = MW'(DEFAULT_MASTER);
        any_req = |req;
        // k = NUM_MASTERS lands back on ptr, so a lone owner keeps the bus.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MW'((int'(ptr) + k) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant      = '0;
        grant[idx] = 1'b1;
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite bus arbiter: round-robin grant with parking, held through fixed
// bursts and locked sequences; hmaster/hmastlock trail hgrant by one accepted cycle.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state, state_nxt;
    logic [4:0]             beat_cnt, beat_cnt_nxt;
    logic [4:0]             beats;
    logic [MW-1:0]          rr_ptr, grant_idx, pick_idx;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic                   pick_any, accepted, owner_lock, rearb;

    ahb_rr_picker #(
        .NUM_MASTERS   (NUM_MASTERS),
        .DEFAULT_MASTER(DEFAULT_MASTER),
        .MW            (MW)
    ) u_picker (
        .req    (hbusreq),
        .ptr    (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any_req(pick_any)
    );

    assign beats      = burst_beats(hburst);
    assign accepted   = hready && (htrans == TR_NONSEQ || htrans == TR_SEQ);
    assign owner_lock = hlock[hmaster];

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        rearb        = 1'b0;
        if (hready) begin
            case (state)
                // Lock entry also holds the grant so the locked owner is not displaced.
                ST_OPEN: begin
                    if (accepted && owner_lock) begin
                        state_nxt = ST_LOCK;
                    end else if (accepted && htrans == TR_NONSEQ && beats > 5'd1) begin
                        state_nxt    = ST_BURST;
                        beat_cnt_nxt = beats - 5'd1;
                    end else begin
                        rearb = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (htrans == TR_SEQ) begin
                        if (beat_cnt == 5'd1) begin
                            state_nxt    = ST_OPEN;
                            beat_cnt_nxt = 5'd0;
                            rearb        = 1'b1;
                        end else begin
                            beat_cnt_nxt = beat_cnt - 5'd1;
                        end
                    end else if (htrans == TR_NONSEQ || htrans == TR_IDLE) begin
                        state_nxt    = ST_OPEN;
                        beat_cnt_nxt = 5'd0;
                    end
                end
                ST_LOCK: begin
                    if (!owner_lock) state_nxt = ST_LOCK_TAIL;
                end
                ST_LOCK_TAIL: begin
                    state_nxt = ST_OPEN;
                    rearb     = 1'b1;
                end
                default: state_nxt = ST_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OPEN;
            beat_cnt  <= 5'd0;
            rr_ptr    <= MW'(DEFAULT_MASTER);
            grant_idx <= MW'(DEFAULT_MASTER);
            hgrant    <= DEF_GRANT;
            hmaster   <= MW'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
        end else if (hready) begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            hmaster   <= grant_idx;
            hmastlock <= hlock[grant_idx];
            if (rearb) begin
                hgrant    <= pick_grant;
                grant_idx <= pick_idx;
                // Parking and self-regrant leave the rotation point alone.
                if (pick_any && pick_idx != grant_idx) rr_ptr <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: rule-level model checked every cycle,
// plus hand-computed grant/counter expectations at key points of each scenario.
module tb_ahb_bus_arbiter;
    import ahb_arb_pkg::*;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] hbusreq, hlock, hgrant;
    logic [1:0]   htrans, hmaster;
    logic [2:0]   hburst;
    logic         hready, hmastlock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index, address-phase owner/lock, rotation point, hold mode, beats left.
    int   m_g, m_mst, m_rr, m_mode, m_left;
    logic m_lk;
    int   len_tab [8] = '{1, 0, 4, 4, 8, 8, 16, 16};
    localparam int M_FREE = 0, M_BURST = 1, M_LOCK = 2, M_TAIL = 3;

    ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .clk      (clk),
        .rst      (rst),
        .hbusreq  (hbusreq),
        .hlock    (hlock),
        .htrans   (htrans),
        .hburst   (hburst),
        .hready   (hready),
        .hgrant   (hgrant),
        .hmaster  (hmaster),
        .hmastlock(hmastlock)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        logic [1:0] i;
        for (int k = 1; k <= N; k++) begin
            i = 2'((ptr + k) % N);
            if (req[i]) return int'(i);
        end
        return DEF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic acc, rearb;
        int   len, ng;
        if (rst) begin
            m_g = DEF; m_mst = DEF; m_lk = 1'b0; m_rr = DEF; m_mode = M_FREE; m_left = 0;
            return;
        end
        if (!hready) return;
        acc   = (htrans == TR_NONSEQ || htrans == TR_SEQ);
        rearb = 1'b0;
        len   = len_tab[hburst];
        case (m_mode)
            M_FREE:
                if (acc && hlock[m_mst]) m_mode = M_LOCK;
                else if (htrans == TR_NONSEQ && len > 1) begin m_mode = M_BURST; m_left = len - 1; end
                else rearb = 1'b1;
            M_BURST:
                if (htrans == TR_SEQ) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_FREE; rearb = 1'b1; end
                end else if (htrans != TR_BUSY) begin
                    m_mode = M_FREE; m_left = 0;
                end
            M_LOCK:  if (!hlock[m_mst]) m_mode = M_TAIL;
            default: begin m_mode = M_FREE; rearb = 1'b1; end
        endcase
        m_lk  = hlock[m_g];
        m_mst = m_g;
        if (rearb) begin
            ng = pick(hbusreq, m_rr);
            if (hbusreq != '0 && ng != m_g) m_rr = ng;
            m_g = ng;
        end
    endtask

    // One clock: drive, step the model on the edge, compare on the falling edge.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        rst = r; hbusreq = rq; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cyc_grant",     int'(hgrant),    1 << m_g);
        check("cyc_hmaster",   int'(hmaster),   m_mst);
        check("cyc_hmastlock", int'(hmastlock), int'(m_lk));
        check("cyc_onehot",    int'($onehot(hgrant)), 1);
    endtask

    // Hand-computed grant pins both the DUT and the model.
    task automatic pin(input string name, input int gnt);
        check({name, "_dut"},   int'(hgrant), gnt);
        check({name, "_model"}, 1 << m_g,     gnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_g [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        int exp_m [4] = '{0, 1, 2, 1};

        // Reset and idle parking
        cyc(1, 4'b0000, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        cyc(1, 4'b0000, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        pin("reset_grant", 4'b0001);
        check("reset_hmaster", int'(hmaster), 0);
        check("reset_hmastlock", int'(hmastlock), 0);
        repeat (5) cyc(0, 4'b0000, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        pin("idle_hold", 4'b0001);

        // Round-robin between masters 1 and 2
        for (int i = 0; i < 4; i++) begin
            cyc(0, 4'b0110, 4'b0000, TR_NONSEQ, BU_SINGLE, 1);
            pin("rr_grant", exp_g[i]);
            check("rr_hmaster", int'(hmaster), exp_m[i]);
        end

        // INCR8 by master 2, master 3 waits for the last beat
        cyc(0, 4'b0100, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        check("incr8_owner", int'(hmaster), 2);
        cyc(0, 4'b0100, 4'b0000, TR_NONSEQ, BU_INCR8, 1);
        pin("incr8_b1", 4'b0100);
        for (int b = 2; b <= 8; b++) begin
            cyc(0, 4'b1100, 4'b0000, TR_SEQ, BU_INCR8, 1);
            pin("incr8_beat", (b < 8) ? 4'b0100 : 4'b1000);
        end

        // INCR4 by master 3 with a 3-cycle stall on beat 2
        cyc(0, 4'b1000, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        cyc(0, 4'b1001, 4'b0000, TR_NONSEQ, BU_INCR4, 1);
        check("incr4_cnt_load", int'(dut.beat_cnt), 3);
        repeat (3) cyc(0, 4'b1001, 4'b0000, TR_SEQ, BU_INCR4, 0);
        pin("incr4_stall", 4'b1000);
        check("incr4_cnt_stall", int'(dut.beat_cnt), 3);
        check("incr4_hmaster_stall", int'(hmaster), 3);
        cyc(0, 4'b1001, 4'b0000, TR_SEQ, BU_INCR4, 1);
        cyc(0, 4'b1001, 4'b0000, TR_SEQ, BU_INCR4, 1);
        pin("incr4_b3", 4'b1000);
        cyc(0, 4'b1001, 4'b0000, TR_SEQ, BU_INCR4, 1);
        pin("incr4_handover", 4'b0001);

        // Locked sequence by master 1 while master 0 requests
        cyc(0, 4'b0010, 4'b0010, TR_IDLE, BU_SINGLE, 1);
        cyc(0, 4'b0010, 4'b0010, TR_IDLE, BU_SINGLE, 1);
        check("lock_owner", int'(hmaster), 1);
        check("lock_mastlock", int'(hmastlock), 1);
        repeat (3) begin
            cyc(0, 4'b0011, 4'b0010, TR_NONSEQ, BU_SINGLE, 1);
            pin("lock_hold", 4'b0010);
            check("lock_mastlock_seq", int'(hmastlock), 1);
        end
        cyc(0, 4'b0011, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        pin("lock_release", 4'b0010);
        check("lock_mastlock_drop", int'(hmastlock), 0);
        cyc(0, 4'b0011, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        pin("lock_tail_exit", 4'b0001);

        // Reset on beat 3 of INCR16
        cyc(0, 4'b0001, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        cyc(0, 4'b0011, 4'b0000, TR_NONSEQ, BU_INCR16, 1);
        check("incr16_cnt_load", int'(dut.beat_cnt), 15);
        cyc(0, 4'b0011, 4'b0000, TR_SEQ, BU_INCR16, 1);
        check("incr16_cnt_b2", int'(dut.beat_cnt), 14);
        cyc(1, 4'b0011, 4'b0000, TR_SEQ, BU_INCR16, 1);
        pin("rst_mid_grant", 4'b0001);
        check("rst_mid_state", int'(dut.state == ST_OPEN), 1);
        check("rst_mid_cnt", int'(dut.beat_cnt), 0);

        // Undefined INCR gives way; idle bus parks on the default master
        cyc(0, 4'b0101, 4'b0000, TR_NONSEQ, BU_INCR, 1);
        pin("incr_rearb", 4'b0100);
        cyc(0, 4'b0000, 4'b0000, TR_IDLE, BU_SINGLE, 1);
        pin("park", 4'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
